// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: shared prescaled period counter (edge or center aligned),
// per-channel compare with full-on/off handling, and a valid/ack shadow-register duty update.
module pwm_gen_multi #(
   parameter int CHANNELS   = 4,
   parameter int CNT_W      = 8,
   parameter int DUTY_W     = 16,
   parameter int PRESCALE_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       center_mode,
   input  logic [PRESCALE_W-1:0]      prescale,
   input  logic [CHANNELS*DUTY_W-1:0] duty,
   input  logic                       duty_valid,
   output logic                       duty_ack,
   input  logic [CHANNELS-1:0]        invert,
   output logic [CHANNELS-1:0]        pwm_out,
   output logic                       period_start
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PRESCALE_W-1:0] r_pre_cnt;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_dir_down;
   logic                  r_mode_act;
   logic                  r_pend_flag;
   logic [CNT_W-1:0]      r_pend [CHANNELS];
   logic [CNT_W-1:0]      r_act  [CHANNELS];
   logic                  r_duty_ack;
   logic                  r_period_start;
   logic [CHANNELS-1:0]   r_pwm;

   logic                  w_tick;
   logic                  w_boundary;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_dir_nxt;
   logic [CHANNELS-1:0]   w_raw;
   logic [CHANNELS*DUTY_W-1:0] w_unused_duty;

   // Only the top CNT_W bits of each duty word matter.
   assign w_unused_duty = duty;

   // A count above a freshly lowered prescale runs on to its natural wrap.
   assign w_tick = en && (r_pre_cnt == prescale);

   // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      w_cnt_nxt  = r_cnt + CNT_W'(1);
      w_dir_nxt  = r_dir_down;
      w_boundary = 1'b0;
      if (!r_mode_act) begin
         if (r_cnt == CNT_MAX) begin
            w_cnt_nxt  = '0;
            w_boundary = w_tick;
         end
      end else if (!r_dir_down) begin
         if (r_cnt == CNT_MAX) begin
            w_cnt_nxt = CNT_MAX - CNT_W'(1);
            w_dir_nxt = 1'b1;
         end
      end else begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            w_dir_nxt  = 1'b0;
            w_boundary = w_tick;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre_cnt      <= '0;
         r_cnt          <= '0;
         r_dir_down     <= 1'b0;
         r_mode_act     <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_boundary;
         if (w_boundary) r_mode_act <= center_mode;
         if (!en) begin
            r_pre_cnt  <= '0;
            r_cnt      <= '0;
            r_dir_down <= 1'b0;
         end else if (w_tick) begin
            r_pre_cnt  <= '0;
            r_cnt      <= w_cnt_nxt;
            r_dir_down <= w_dir_nxt;
         end else begin
            r_pre_cnt  <= r_pre_cnt + PRESCALE_W'(1);
         end
      end
   end

   // NOTE: the duty buffers are small register arrays, so they are cleared on reset like any other state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_flag <= 1'b0;
         r_duty_ack  <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_pend[i] <= '0;
            r_act[i]  <= '0;
         end
      end else begin
         // A write on the boundary edge stays pending; the transfer takes the older contents.
         r_pend_flag <= duty_valid | (r_pend_flag & ~w_boundary);
         r_duty_ack  <= w_boundary & r_pend_flag;
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_boundary && r_pend_flag) r_act[i] <= r_pend[i];
            if (duty_valid) r_pend[i] <= duty[i*DUTY_W + DUTY_W - CNT_W +: CNT_W];
         end
      end
   end

   always_comb begin
      w_raw = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_raw[i] = en && ((r_act[i] == CNT_MAX) || (r_cnt < r_act[i]));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= w_raw ^ invert;
      end
   end

   assign pwm_out      = r_pwm;
   assign duty_ack     = r_duty_ack;
   assign period_start = r_period_start;

endmodule
